// File: rtl/load_unit.sv
// Load unit: issues a word-aligned memory read, then extracts and extends the byte/half/word.
// Latency: 3 cycles minimum to rsp_valid; misaligned/illegal loads respond the next cycle; rsp_* held until rsp_ready.
module load_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_f3,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_misaligned,
  output logic        rsp_access_fault,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  // Counter value seen in the final WAIT cycle before the timeout fires.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        mis_q, mis_d;
  logic        fault_q, fault_d;

  function automatic logic bad_load(input logic [1:0] off, input logic [2:0] f3);
    bad_load = 1'b0;
    case (f3)
      3'b000, 3'b100: bad_load = 1'b0;
      3'b001, 3'b101: bad_load = off[0];
      3'b010:         bad_load = (off != 2'b00);
      default:        bad_load = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    extract = w;
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'h0, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'h0, h};
      default: extract = w;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mis_d   = mis_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          f3_d   = req_f3;
          rd_d   = req_rd;
          if (bad_load(req_addr[1:0], req_f3)) begin
            state_d = RESP;
            mis_d   = 1'b1;
            fault_d = 1'b0;
            data_d  = 32'h0;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_d = WAIT;
          cnt_d   = 8'h0;
        end
      end
      WAIT: begin
        // A response arriving on the expiry cycle takes priority over the timeout.
        if (mem_rvalid) begin
          state_d = RESP;
          mis_d   = 1'b0;
          fault_d = mem_err;
          data_d  = mem_err ? 32'h0 : extract(mem_rdata, addr_q[1:0], f3_q);
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          mis_d   = 1'b0;
          fault_d = 1'b1;
          data_d  = 32'h0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      f3_q    <= 3'h0;
      rd_q    <= 5'h0;
      cnt_q   <= 8'h0;
      data_q  <= 32'h0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mis_q   <= mis_d;
      fault_q <= fault_d;
    end
  end

  assign req_ready        = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign mem_req          = (state_q == REQ);
  assign mem_addr         = {addr_q[31:2], 2'b00};
  assign rsp_valid        = (state_q == RESP);
  assign rsp_data         = data_q;
  assign rsp_rd           = rd_q;
  assign rsp_misaligned   = mis_q;
  assign rsp_access_fault = fault_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed and randomized checks of load_unit against a behavioural load model.
module tb_load_unit;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic [2:0]  req_f3 = 3'h0;
  logic [4:0]  req_rd = 5'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_err = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_misaligned;
  logic        rsp_access_fault;
  logic        busy;

  int ncmp = 0;
  int nerr = 0;

  load_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_f3(req_f3), .req_rd(req_rd),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_misaligned(rsp_misaligned),
    .rsp_access_fault(rsp_access_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected response from the load rules, using shifts and masks on the whole word.
  task automatic model(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] rdata,
                       input bit err, input bit tmo,
                       output logic [31:0] data, output bit mis, output bit fault);
    int unsigned off, v;
    off   = addr % 4;
    mis   = 1'b0;
    fault = 1'b0;
    data  = 32'h0;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) mis = 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (off % 2 != 0)) mis = 1'b1;
    if (f3 == 3'd2 && off != 0) mis = 1'b1;
    if (mis) return;
    if (tmo || err) begin
      fault = 1'b1;
      return;
    end
    case (f3)
      3'd0, 3'd4: begin
        v = (rdata >> (8 * off)) & 32'hFF;
        if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFFFF00;
      end
      3'd1, 3'd5: begin
        v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF0000;
      end
      default: v = rdata;
    endcase
    data = v;
  endtask

  // rv_dly < 0 means no response at all (timeout expected).
  task automatic run_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] rdata, input bit err, input int gnt_dly,
                          input int rv_dly, input bit stray, input int hold);
    logic [31:0] e_data;
    bit e_mis, e_fault;
    int n;
    model(addr, f3, rdata, err, rv_dly < 0, e_data, e_mis, e_fault);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_f3    = f3;
    req_rd    = rd;
    tick();
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_f3    = 3'($urandom);
    req_rd    = 5'($urandom);
    if (e_mis) begin
      chk("mis_no_mem_req", mem_req, 0);
    end else begin
      for (int i = 0; i < gnt_dly; i++) begin
        chk("req_mem_req", mem_req, 1);
        chk("req_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        if (stray && i == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = $urandom;
          mem_err    = 1'b1;
        end
        tick();
        mem_rvalid = 1'b0;
        mem_err    = 1'b0;
      end
      chk("gnt_mem_req", mem_req, 1);
      chk("gnt_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk("wait_mem_req", mem_req, 0);
      if (rv_dly < 0) begin
        n = 0;
        while (!rsp_valid && n < TO + 5) begin
          tick();
          n++;
        end
        chk("timeout_cycles", n, TO);
      end else begin
        for (int i = 0; i < rv_dly; i++) tick();
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        mem_err    = err;
        tick();
        mem_rvalid = 1'b0;
        mem_err    = 1'b0;
        mem_rdata  = $urandom;
      end
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, e_data);
    chk("rsp_rd", rsp_rd, 32'(rd));
    chk("rsp_mis", rsp_misaligned, 32'(e_mis));
    chk("rsp_fault", rsp_access_fault, 32'(e_fault));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, e_data);
      chk("hold_rd", rsp_rd, 32'(rd));
      chk("hold_flags", {rsp_misaligned, rsp_access_fault}, {e_mis, e_fault});
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    chk("hs_req_ready", req_ready, 0);
    tick();
    rsp_ready = 1'b0;
    chk("after_rsp_valid", rsp_valid, 0);
    chk("after_busy", busy, 0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_rd", rsp_rd, 0);
    chk("rst_flags", {rsp_misaligned, rsp_access_fault}, 0);
    rst_n = 1'b1;
    tick();

    run_load(32'h1003, 3'b000, 5'd7,  32'h80FF1234, 0, 0, 0, 0, 0);
    run_load(32'h1003, 3'b100, 5'd9,  32'h80FF1234, 0, 0, 0, 0, 0);
    run_load(32'h2002, 3'b001, 5'd3,  32'h80017FFF, 0, 0, 0, 0, 0);
    run_load(32'h2002, 3'b101, 5'd4,  32'h80017FFF, 0, 0, 0, 0, 0);
    run_load(32'h2001, 3'b001, 5'd5,  32'h12345678, 0, 0, 0, 0, 0);
    run_load(32'h2000, 3'b011, 5'd6,  32'h12345678, 0, 0, 0, 0, 0);
    run_load(32'h3000, 3'b010, 5'd11, 32'hDEADBEEF, 0, 3, 5, 1, 0);
    run_load(32'h3004, 3'b010, 5'd12, 32'h0, 0, 0, -1, 0, 0);
    run_load(32'h3008, 3'b010, 5'd13, 32'hCAFEF00D, 0, 0, TO - 1, 0, 0);
    run_load(32'h300C, 3'b010, 5'd14, 32'h55AA55AA, 1, 1, 2, 0, 4);

    // Reset in WAIT abandons the load; a late response must be ignored.
    req_valid = 1'b1;
    req_addr  = 32'h4000;
    req_f3    = 3'b010;
    req_rd    = 5'd20;
    tick();
    req_valid = 1'b0;
    mem_gnt   = 1'b1;
    tick();
    mem_gnt = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_busy", busy, 0);
    tick();
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11112222;
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_rvalid_rsp", rsp_valid, 0);
      chk("late_rvalid_busy", busy, 0);
      tick();
    end
    run_load(32'h5000, 3'b010, 5'd21, 32'h0BADCAFE, 0, 0, 0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      logic [2:0] f3s [8];
      int idx, rv;
      f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
      idx = $urandom_range(0, 9);
      rv  = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, TO - 1);
      run_load($urandom, (idx > 7) ? 3'd2 : f3s[idx], 5'($urandom), $urandom,
               $urandom_range(0, 7) == 0, $urandom_range(0, 3), rv,
               1'($urandom), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
